// File: rtl/dvs_event_fifo_bus.sv
// Shared event-word width and the event FIFO bus that arbitrates the
// DVS event interfaces into one FWFT queue for the RAVENS consumer.
package dvs_ravens_pkg;
    localparam int EVENT_BITS = 12;
endpackage

module dvs_event_fifo_bus #(
    parameter int NUM_REQ    = 2,
    parameter int EVENT_BITS = dvs_ravens_pkg::EVENT_BITS,
    parameter int DEPTH      = 16,
    parameter int ADDR_BITS  = $clog2(DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            fifo_req,
    input  logic [NUM_REQ-1:0]            fifo_wr_en,
    input  logic [NUM_REQ*EVENT_BITS-1:0] fifo_event,
    output logic [NUM_REQ-1:0]            fifo_grant,
    output logic [EVENT_BITS-1:0]         out_event,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ADDR_BITS:0]            count,
    output logic                          overflow,
    output logic                          collision
);

    localparam int RR_BITS = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [EVENT_BITS-1:0] mem [DEPTH];
    logic [ADDR_BITS-1:0]  wr_ptr;
    logic [ADDR_BITS-1:0]  rd_ptr;
    logic [NUM_REQ-1:0]    wr_allow;
    logic [RR_BITS-1:0]    rr_last;
    logic [NUM_REQ-1:0]    eligible;
    logic [NUM_REQ-1:0]    grant_nxt;
    logic [RR_BITS-1:0]    grant_idx;
    logic                  found;
    logic [ADDR_BITS+1:0]  reserved;
    logic [EVENT_BITS-1:0] wr_word;
    logic                  full;
    logic                  pop;
    logic                  push;
    logic                  multi;
    logic                  ovf_set;
    int                    idx;

    assign full      = (count == (ADDR_BITS+1)'(DEPTH));
    assign out_valid = (count != '0);
    assign out_event = out_valid ? mem[rd_ptr] : '0;
    assign pop       = out_valid & out_ready;
    assign multi     = (|fifo_wr_en) & ~$onehot(fifo_wr_en);
    assign ovf_set   = (|fifo_wr_en) & full & ~pop;

    // Only the requester granted last cycle may land a word; stale strobes
    // left over from a reset are dropped here.
    assign push = $onehot(fifo_wr_en) & (fifo_wr_en == wr_allow)
                & (~full | pop);

    assign reserved = {1'b0, count}
                    + {{(ADDR_BITS+1){1'b0}}, |fifo_grant}
                    + {{(ADDR_BITS+1){1'b0}}, |fifo_wr_en};

    always_comb begin
        wr_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (fifo_wr_en[i]) wr_word = fifo_event[i*EVENT_BITS +: EVENT_BITS];
        end
    end

    // Smallest offset from the last winner wins, so scan offsets downwards.
    always_comb begin
        eligible  = fifo_req & ~fifo_grant;
        grant_nxt = '0;
        grant_idx = rr_last;
        found     = 1'b0;
        idx       = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(rr_last) + k) % NUM_REQ;
            if (eligible[idx]) begin
                found     = 1'b1;
                grant_idx = RR_BITS'(idx);
            end
        end
        if (found && (reserved < (ADDR_BITS+2)'(DEPTH))) begin
            grant_nxt[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_grant <= '0;
            wr_allow   <= '0;
            rr_last    <= RR_BITS'(NUM_REQ-1);
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            collision  <= 1'b0;
        end else begin
            fifo_grant <= grant_nxt;
            wr_allow   <= fifo_grant;
            if (|grant_nxt) rr_last <= grant_idx;
            if (push) wr_ptr <= wr_ptr + ADDR_BITS'(1);
            if (pop) rd_ptr <= rd_ptr + ADDR_BITS'(1);
            if (push && !pop) begin
                count <= count + (ADDR_BITS+1)'(1);
            end else if (pop && !push) begin
                count <= count - (ADDR_BITS+1)'(1);
            end
            if (multi) collision <= 1'b1;
            if (ovf_set) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_word;
    end

endmodule

// File: tb/tb_dvs_event_fifo_bus.sv
// Randomised bench for dvs_event_fifo_bus against a queue-based
// model of the grant/write/read rules.
module tb_dvs_event_fifo_bus;

    localparam int NR    = 2;
    localparam int EB    = 12;
    localparam int DEPTH = 16;
    localparam int AB    = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     fifo_req;
    logic [NR-1:0]     fifo_wr_en;
    logic [NR*EB-1:0]  fifo_event;
    logic [NR-1:0]     fifo_grant;
    logic [EB-1:0]     out_event;
    logic              out_valid;
    logic              out_ready;
    logic [AB:0]       count;
    logic              overflow;
    logic              collision;

    always #5 clk = ~clk;

    dvs_event_fifo_bus #(
        .NUM_REQ(NR), .EVENT_BITS(EB), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .fifo_req(fifo_req), .fifo_wr_en(fifo_wr_en),
        .fifo_event(fifo_event), .fifo_grant(fifo_grant),
        .out_event(out_event), .out_valid(out_valid),
        .out_ready(out_ready), .count(count),
        .overflow(overflow), .collision(collision)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference state: queue contents, grant this cycle / last cycle.
    logic [EB-1:0] q[$];
    logic [NR-1:0] m_grant;
    logic [NR-1:0] m_gprev;
    int            m_last;
    bit            m_ovf;
    bit            m_col;
    logic [EB-1:0] word [NR];

    task automatic model_reset();
        q.delete();
        m_grant = '0;
        m_gprev = '0;
        m_last  = NR - 1;
        m_ovf   = 1'b0;
        m_col   = 1'b0;
    endtask

    task automatic check_outputs();
        chk("grant", 32'(fifo_grant), 32'(m_grant));
        chk("valid", 32'(out_valid), 32'(q.size() != 0));
        chk("count", 32'(count), 32'(q.size()));
        if (q.size() != 0) chk("event", 32'(out_event), 32'(q[0]));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("collision", 32'(collision), 32'(m_col));
    endtask

    task automatic model_update(input logic [NR-1:0] req,
                                input logic [NR-1:0] wr,
                                input logic ready);
        int cnt, nw, res, widx;
        bit pop, push;
        logic [NR-1:0] ng;
        cnt  = q.size();
        pop  = (cnt > 0) && ready;
        nw   = $countones(wr);
        res  = cnt + int'(m_grant != 0) + int'(wr != 0);
        push = (nw == 1) && (wr == m_gprev) && (cnt < DEPTH || pop);
        if (nw > 1) m_col = 1'b1;
        if (wr != 0 && cnt == DEPTH && !pop) m_ovf = 1'b1;
        ng = '0;
        if (res < DEPTH) begin
            for (int k = 1; k <= NR; k++) begin
                int j;
                j = (m_last + k) % NR;
                if (req[j] && !m_grant[j]) begin
                    ng[j]  = 1'b1;
                    m_last = j;
                    break;
                end
            end
        end
        widx = 0;
        for (int i = 0; i < NR; i++) if (wr[i]) widx = i;
        if (pop) void'(q.pop_front());
        if (push) q.push_back(word[widx]);
        m_gprev = m_grant;
        m_grant = ng;
    endtask

    // One cycle: check, drive, clock, advance model.
    task automatic step(input logic [NR-1:0] req, input logic ready,
                        input bit frc, input logic [NR-1:0] fwr,
                        input bit use_w0, input logic [EB-1:0] w0);
        logic [NR-1:0] wr;
        check_outputs();
        for (int i = 0; i < NR; i++) word[i] = EB'($urandom);
        if (use_w0) word[0] = w0;
        wr = frc ? fwr : m_gprev;
        for (int i = 0; i < NR; i++) fifo_event[i*EB +: EB] = word[i];
        fifo_req   = req;
        fifo_wr_en = wr;
        out_ready  = ready;
        @(posedge clk);
        model_update(req, wr, ready);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NR-1:0] last_g;
        int ngr, b;
        rst_n      = 1'b0;
        fifo_req   = '0;
        fifo_wr_en = '0;
        fifo_event = '0;
        out_ready  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_event", 32'(out_event), 32'h0);
        check_outputs();
        rst_n = 1'b1;

        // Single request from requester 0 writing 0x0A5.
        step(2'b01, 1'b0, 1'b0, '0, 1'b1, 12'h0A5);
        chk("t1_grant", 32'(fifo_grant), 32'h1);
        step(2'b00, 1'b0, 1'b0, '0, 1'b1, 12'h0A5);
        chk("t1_pulse", 32'(fifo_grant), 32'h0);
        step(2'b00, 1'b0, 1'b0, '0, 1'b1, 12'h0A5);
        chk("t1_valid", 32'(out_valid), 32'h1);
        chk("t1_event", 32'(out_event), 32'h0A5);
        chk("t1_count", 32'(count), 32'h1);
        step(2'b00, 1'b1, 1'b0, '0, 1'b0, '0);

        // Both requesting continuously, consumer always ready.
        last_g = '0;
        for (int n = 0; n < 40; n++) begin
            if (fifo_grant != 0) begin
                chk("no_repeat", 32'(fifo_grant & last_g), 32'h0);
            end
            last_g = fifo_grant;
            step(2'b11, 1'b1, 1'b0, '0, 1'b0, '0);
        end

        for (int n = 0; n < 300; n++) begin
            step(NR'($urandom), 1'($urandom), 1'b0, '0, 1'b0, '0);
        end

        // Fill with consumer stalled.
        for (int n = 0; n < 60; n++) step(2'b11, 1'b0, 1'b0, '0, 1'b0, '0);
        chk("full_count", 32'(count), 32'd16);
        chk("full_ovf", 32'(overflow), 32'h0);
        chk("full_nogrant", 32'(fifo_grant), 32'h0);

        // One pop lets exactly one new grant through.
        step(2'b11, 1'b1, 1'b0, '0, 1'b0, '0);
        ngr = 0;
        for (int n = 0; n < 8; n++) begin
            if (fifo_grant != 0) ngr++;
            step(2'b11, 1'b0, 1'b0, '0, 1'b0, '0);
        end
        chk("one_regrant", 32'(ngr), 32'd1);
        chk("refill_count", 32'(count), 32'd16);

        // Forced collision, then forced write into a full FIFO.
        step(2'b00, 1'b0, 1'b0, '0, 1'b0, '0);
        step(2'b00, 1'b0, 1'b1, 2'b11, 1'b0, '0);
        chk("col_set", 32'(collision), 32'h1);
        chk("col_nopush", 32'(count), 32'd16);
        step(2'b00, 1'b0, 1'b1, 2'b01, 1'b0, '0);
        chk("ovf_set", 32'(overflow), 32'h1);

        // Drain to 6, then build to 7 with a grant outstanding.
        b = 0;
        while (q.size() > 6 && b < 40) begin
            step(2'b00, 1'b1, 1'b0, '0, 1'b0, '0);
            b++;
        end
        chk("drain_bound", 32'(b < 40), 32'h1);
        b = 0;
        while (!(q.size() == 7 && m_grant != 0) && b < 40) begin
            step(2'b01, 1'b0, 1'b0, '0, 1'b0, '0);
            b++;
        end
        chk("build_bound", 32'(b < 40), 32'h1);
        check_outputs();
        chk("flags_held", 32'({overflow, collision}), 32'h3);

        #2;
        rst_n      = 1'b0;
        fifo_req   = '0;
        fifo_wr_en = '0;
        #1;
        model_reset();
        chk("mid_rst_count", 32'(count), 32'h0);
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_grant", 32'(fifo_grant), 32'h0);
        chk("mid_rst_flags", 32'({overflow, collision}), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Late strobe from the pre-reset grant must not push.
        step(2'b00, 1'b0, 1'b1, 2'b01, 1'b0, '0);
        chk("stale_wr", 32'(count), 32'h0);
        step(2'b11, 1'b1, 1'b0, '0, 1'b0, '0);
        chk("restart_r0", 32'(fifo_grant), 32'h1);
        for (int n = 0; n < 12; n++) step(2'b11, 1'b1, 1'b0, '0, 1'b0, '0);
        check_outputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
